// File: rtl/ternary_pkg.sv
// Shared types, opcodes, weight encodings and width helpers for the ternary
// matrix-vector multiply core.
package ternary_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'hA;
  localparam logic [3:0] OP_MULT = 4'hB;

  localparam logic [1:0] W_POS = 2'b01;
  localparam logic [1:0] W_NEG = 2'b11;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int acc_w(input int act_w, input int max_in);
    return act_w + $clog2(max_in) + 1;
  endfunction

endpackage

// File: rtl/ternary_weight_mem.sv
// 2-bit ternary weight store: one 16-bit packed word written per cycle,
// a whole row read combinationally for the accumulate datapath.
module ternary_weight_mem #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int RW          = 4,
  parameter int WW          = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [RW-1:0]            wr_row,
  input  logic [WW-1:0]            wr_word,
  input  logic [15:0]              wr_data,
  input  logic [RW-1:0]            rd_row,
  output logic [2*MAX_OUT_LEN-1:0] rd_data
);

  localparam int WPR = MAX_OUT_LEN / 8;

  logic [2*MAX_OUT_LEN-1:0] mem [MAX_IN_LEN];

  // Cleared on reset so a MULT issued before any LOAD sees all-zero weights.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < MAX_IN_LEN; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < WPR; k++) begin
        if (wr_word == WW'(k)) begin
          mem[wr_row][16*k +: 16] <= wr_data;
        end
      end
    end
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/ternary_mvm_core.sv
// Streaming ternary matrix-vector multiply: load {-1,0,+1} weights, stream
// activations row by row, then emit one signed dot product per column.
module ternary_mvm_core
  import ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int ACT_W       = 8,
  localparam int ACC_W      = acc_w(ACT_W, MAX_IN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int LI  = idx_w(MAX_IN_LEN);
  localparam int LO  = idx_w(MAX_OUT_LEN);
  localparam int WPR = MAX_OUT_LEN / 8;
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;

  state_t                   state;
  logic [LI:0]              in_len;
  logic [LO:0]              out_len;
  logic [LI-1:0]            row_cnt;
  logic [WW-1:0]            word_cnt;
  logic [LO-1:0]            col;

  logic signed [ACC_W-1:0]  acc      [MAX_OUT_LEN];
  logic signed [ACC_W-1:0]  acc_next [MAX_OUT_LEN];
  logic signed [ACC_W-1:0]  act_ext;
  logic [2*MAX_OUT_LEN-1:0] row_w;
  logic [15:0]              wr_masked;
  logic [3:0]               opcode;
  logic                     row_last;
  logic                     word_last;
  logic                     col_next_last;
  logic                     acc_clr;
  logic                     acc_en;
  logic                     wr_en;

  assign opcode        = in_data[15:12];
  assign act_ext       = ACC_W'($signed(in_data[ACT_W-1:0]));
  assign row_last      = ((LI+1)'(row_cnt) == in_len - (LI+1)'(1));
  assign word_last     = (word_cnt == WW'(WPR - 1));
  assign col_next_last = ((LO+1)'(col) + (LO+1)'(2) == out_len);
  assign acc_clr       = (state == IDLE) && in_valid && (opcode == OP_MULT);
  assign acc_en        = (state == MULT) && in_valid;
  assign wr_en         = (state == LOAD) && in_valid;
  assign in_ready      = (state != OUT);
  assign busy          = (state != IDLE);

  genvar gi;

  // Columns past out_len are written as zero so stale data never contributes.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign wr_masked[2*gi +: 2] =
        ((8 * int'(word_cnt) + gi) < int'(out_len)) ? in_data[2*gi +: 2] : 2'b00;
    end
  endgenerate

  ternary_weight_mem #(
    .MAX_IN_LEN (MAX_IN_LEN),
    .MAX_OUT_LEN(MAX_OUT_LEN),
    .RW         (LI),
    .WW         (WW)
  ) u_weight_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_row (row_cnt),
    .wr_word(word_cnt),
    .wr_data(wr_masked),
    .rd_row (row_cnt),
    .rd_data(row_w)
  );

  generate
    for (gi = 0; gi < MAX_OUT_LEN; gi++) begin : g_col
      logic [1:0] w_code;
      logic       col_on;
      assign w_code = row_w[2*gi +: 2];
      assign col_on = (gi < int'(out_len));
      assign acc_next[gi] = !col_on             ? acc[gi] :
                            (w_code == W_POS)   ? acc[gi] + act_ext :
                            (w_code == W_NEG)   ? acc[gi] - act_ext :
                                                  acc[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUT_LEN; i++) acc[i] <= '0;
    end else if (acc_clr) begin
      for (int i = 0; i < MAX_OUT_LEN; i++) acc[i] <= '0;
    end else if (acc_en) begin
      for (int i = 0; i < MAX_OUT_LEN; i++) acc[i] <= acc_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_len    <= (LI+1)'(MAX_IN_LEN);
      out_len   <= (LO+1)'(MAX_OUT_LEN);
      row_cnt   <= '0;
      word_cnt  <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && opcode == OP_LOAD) begin
            in_len   <= (LI+1)'(in_data[11 -: LI]) + (LI+1)'(1);
            out_len  <= (LO+1)'(in_data[11-LI -: LO]) + (LO+1)'(1);
            row_cnt  <= '0;
            word_cnt <= '0;
            state    <= LOAD;
          end else if (in_valid && opcode == OP_MULT) begin
            row_cnt <= '0;
            state   <= MULT;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (word_last) begin
              word_cnt <= '0;
              if (row_last) state <= IDLE;
              else          row_cnt <= row_cnt + LI'(1);
            end else begin
              word_cnt <= word_cnt + WW'(1);
            end
          end
        end
        MULT: begin
          if (in_valid) begin
            if (row_last) begin
              // First result leaves with the final activation already folded in.
              state     <= OUT;
              col       <= '0;
              out_valid <= 1'b1;
              out_data  <= acc_next[0];
              out_last  <= (out_len == (LO+1)'(1));
            end else begin
              row_cnt <= row_cnt + LI'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              col       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              col      <= col + LO'(1);
              out_data <= acc[col + LO'(1)];
              out_last <= col_next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_mvm_core.sv
// Self-checking bench for ternary_mvm_core: directed scenarios plus random
// loads/multiplies compared against an array-based reference model.
module tb_ternary_mvm_core;

  localparam int MAX_IN  = 16;
  localparam int MAX_OUT = 8;
  localparam int ACT_W   = 8;
  localparam int ACC_W   = 13;
  localparam int LI      = 4;
  localparam int LO      = 3;
  localparam int WPR     = MAX_OUT / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int w_m [MAX_IN][MAX_OUT];
  int il_m;
  int ol_m;
  int exp_q[$];
  int first_q[$];
  logic [ACC_W-1:0] got_data[$];
  bit               got_last[$];

  always #5 clk = ~clk;

  ternary_mvm_core #(
    .MAX_IN_LEN (MAX_IN),
    .MAX_OUT_LEN(MAX_OUT),
    .ACT_W      (ACT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int r = 0; r < MAX_IN; r++)
      for (int c = 0; c < MAX_OUT; c++) w_m[r][c] = 0;
    il_m = MAX_IN;
    ol_m = MAX_OUT;
  endtask

  task automatic model_load(input int il, input int ol, input logic [15:0] words[$]);
    il_m = il;
    ol_m = ol;
    for (int r = 0; r < il; r++) begin
      for (int c = 0; c < MAX_OUT; c++) begin
        int code;
        code = (words[r*WPR + c/8] >> (2*(c%8))) & 3;
        if (c >= ol)        w_m[r][c] = 0;
        else if (code == 1) w_m[r][c] = 1;
        else if (code == 3) w_m[r][c] = -1;
        else                w_m[r][c] = 0;
      end
    end
  endtask

  task automatic model_mult(input logic [15:0] xs[$]);
    exp_q.delete();
    for (int c = 0; c < ol_m; c++) begin
      int sum;
      sum = 0;
      for (int r = 0; r < il_m; r++) begin
        int v;
        v = int'(xs[r]) & ((1 << ACT_W) - 1);
        if (v >= (1 << (ACT_W-1))) v -= (1 << ACT_W);
        sum += w_m[r][c] * v;
      end
      exp_q.push_back(sum);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_load(input int il, input int ol, input logic [15:0] words[$]);
    logic [15:0] cmd;
    cmd = 16'hA000 | 16'((il-1) << (12-LI)) | 16'((ol-1) << (12-LI-LO));
    send_word(cmd);
    for (int i = 0; i < il*WPR; i++) send_word(words[i]);
    model_load(il, ol, words);
  endtask

  task automatic do_mult(input logic [15:0] xs[$]);
    send_word(16'hB000);
    for (int i = 0; i < il_m; i++) send_word(xs[i]);
    model_mult(xs);
  endtask

  // Gathers up to n output beats; gives up after a fixed cycle budget.
  task automatic collect(input int n, input bit stall);
    int budget;
    got_data.delete();
    got_last.delete();
    budget = 0;
    while (got_data.size() < n && budget < 400) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      @(posedge clk); #1;
      budget++;
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b out_valid=%b out_last=%b out_data=%0d, required 0/0/0/0",
               busy, out_valid, out_last, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_all_plus();
    logic [15:0] words[$];
    logic [15:0] xs[$];
    for (int i = 0; i < 16; i++) words.push_back(16'h5555);
    for (int i = 1; i <= 16; i++) xs.push_back(16'(i));
    do_load(16, 8, words);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL all_plus_load_done: busy=%b, required 0", busy);
    end
    do_mult(xs);
    collect(8, 1'b0);
    tests_run++;
    if (got_data.size() != 8) begin
      tests_failed++;
      $display("FAIL all_plus_beats: got %0d beats, required 8", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== ACC_W'(136) || got_last[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL all_plus_col%0d: data=%0d last=%b, required 136 last=%b",
                 i, $signed(got_data[i]), got_last[i], (i == 7));
      end
    end
  endtask

  task automatic test_mixed_signs();
    logic [15:0] words[$];
    logic [15:0] xs[$];
    int ref_vals[3];
    ref_vals = '{133, 128, 128};
    words = '{16'hFFFF, 16'h0001};
    xs    = '{16'hFF80, 16'h0005};
    do_load(2, 3, words);
    do_mult(xs);
    collect(3, 1'b1);
    tests_run++;
    if (got_data.size() != 3) begin
      tests_failed++;
      $display("FAIL mixed_beats: got %0d beats, required 3", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== ACC_W'(ref_vals[i]) || got_last[i] !== (i == 2)) begin
        tests_failed++;
        $display("FAIL mixed_col%0d: data=%0d last=%b, required %0d last=%b",
                 i, $signed(got_data[i]), got_last[i], ref_vals[i], (i == 2));
      end
    end
    out_ready = 1'b1;
    repeat (3) begin
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL mixed_extra_beat: out_valid=%b busy=%b, required 0/0", out_valid, busy);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] xs[$];
    logic [ACC_W-1:0] held;
    for (int i = 0; i < il_m; i++) xs.push_back(16'($urandom));
    do_mult(xs);
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_cyc%0d: data=%0d valid=%b in_ready=%b, required %0d/1/0",
                 k, out_data, out_valid, in_ready, held);
      end
    end
    collect(exp_q.size(), 1'b1);
    tests_run++;
    if (got_data.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL backpressure_beats: got %0d, required %0d", got_data.size(), exp_q.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== ACC_W'(exp_q[i]) || got_last[i] !== (i == exp_q.size()-1)) begin
        tests_failed++;
        $display("FAIL backpressure_col%0d: data=%0d last=%b, required %0d",
                 i, $signed(got_data[i]), got_last[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_code();
    logic [15:0] words[$];
    logic [15:0] xs[$];
    for (int i = 0; i < 16; i++) words.push_back(16'hAAAA);
    for (int i = 0; i < 16; i++) xs.push_back(16'd100);
    do_load(16, 8, words);
    do_mult(xs);
    collect(8, 1'b0);
    tests_run++;
    if (got_data.size() != 8) begin
      tests_failed++;
      $display("FAIL zero_code_beats: got %0d, required 8", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== '0) begin
        tests_failed++;
        $display("FAIL zero_code_col%0d: data=%0d, required 0", i, $signed(got_data[i]));
      end
    end
  endtask

  task automatic test_reset_mid_mult();
    logic [15:0] words[$];
    logic [15:0] xs[$];
    for (int i = 0; i < 8; i++) words.push_back(16'($urandom));
    do_load(8, 8, words);
    send_word(16'hB000);
    send_word(16'($urandom));
    send_word(16'($urandom));
    in_data = 16'($urandom); in_valid = 1'b1; rst = 1'b1;
    #2;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: busy=%b out_valid=%b, required 0/0", busy, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    model_reset();
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_next: busy=%b out_valid=%b out_last=%b, required 0/0/0",
               busy, out_valid, out_last);
    end
    // Default lengths and cleared weights after reset
    for (int i = 0; i < MAX_IN; i++) xs.push_back(16'($urandom));
    do_mult(xs);
    collect(MAX_OUT, 1'b0);
    tests_run++;
    if (got_data.size() != MAX_OUT) begin
      tests_failed++;
      $display("FAIL reset_default_beats: got %0d, required %0d", got_data.size(), MAX_OUT);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== '0) begin
        tests_failed++;
        $display("FAIL reset_cleared_col%0d: data=%0d, required 0", i, $signed(got_data[i]));
      end
    end
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(16'($urandom));
    do_load(5, 6, words);
    xs.delete();
    for (int i = 0; i < 5; i++) xs.push_back(16'($urandom));
    do_mult(xs);
    collect(exp_q.size(), 1'b1);
    tests_run++;
    if (got_data.size() != 6) begin
      tests_failed++;
      $display("FAIL reset_fresh_beats: got %0d, required 6", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      tests_run++;
      if (got_data[i] !== ACC_W'(exp_q[i]) || got_last[i] !== (i == 5)) begin
        tests_failed++;
        $display("FAIL reset_fresh_col%0d: data=%0d last=%b, required %0d",
                 i, $signed(got_data[i]), got_last[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_opcode_repeat();
    logic [15:0] xs[$];
    send_word(16'h3FFF);
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_opcode: busy=%b in_ready=%b, required 0/1", busy, in_ready);
    end
    for (int i = 0; i < il_m; i++) xs.push_back(16'($urandom));
    first_q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      do_mult(xs);
      collect(exp_q.size(), 1'b1);
      tests_run++;
      if (got_data.size() != exp_q.size()) begin
        tests_failed++;
        $display("FAIL repeat%0d_beats: got %0d, required %0d", pass, got_data.size(), exp_q.size());
      end
      for (int i = 0; i < got_data.size(); i++) begin
        tests_run++;
        if (got_data[i] !== ACC_W'(exp_q[i])) begin
          tests_failed++;
          $display("FAIL repeat%0d_col%0d: data=%0d, required %0d",
                   pass, i, $signed(got_data[i]), exp_q[i]);
        end
        if (pass == 0) first_q.push_back(int'($signed(got_data[i])));
        else begin
          tests_run++;
          if (i < first_q.size() && $signed(got_data[i]) != first_q[i]) begin
            tests_failed++;
            $display("FAIL repeat_identical_col%0d: second=%0d first=%0d",
                     i, $signed(got_data[i]), first_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [15:0] words[$];
      logic [15:0] xs[$];
      int il, ol;
      il = $urandom_range(1, MAX_IN);
      ol = $urandom_range(1, MAX_OUT);
      for (int i = 0; i < il*WPR; i++) words.push_back(16'($urandom));
      do_load(il, ol, words);
      for (int m = 0; m < 2; m++) begin
        xs.delete();
        for (int i = 0; i < il; i++) xs.push_back(16'($urandom));
        do_mult(xs);
        collect(exp_q.size(), 1'b1);
        tests_run++;
        if (got_data.size() != ol) begin
          tests_failed++;
          $display("FAIL random%0d_beats: got %0d, required %0d", it, got_data.size(), ol);
        end
        for (int i = 0; i < got_data.size(); i++) begin
          tests_run++;
          if (got_data[i] !== ACC_W'(exp_q[i]) || got_last[i] !== (i == ol-1)) begin
            tests_failed++;
            $display("FAIL random%0d_col%0d: data=%0d last=%b, required %0d last=%b",
                     it, i, $signed(got_data[i]), got_last[i], exp_q[i], (i == ol-1));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_plus();
    test_mixed_signs();
    test_backpressure();
    test_zero_code();
    test_reset_mid_mult();
    test_bad_opcode_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ternary_mvm_core.md
TERNARY_MVM_CORE -- requirements
Module: ternary_mvm_core

Interface
REQ-001 Parameter MAX_IN_LEN, default 16: max input-vector length (weight rows).
REQ-002 Parameter MAX_OUT_LEN, default 8: max output-vector length (weight columns); SHALL be a multiple of 8.
REQ-003 Parameter ACT_W, default 8: signed activation width, at most 16.
REQ-004 Derived: ACC_W = ACT_W + clog2(MAX_IN_LEN) + 1; LI = clog2(MAX_IN_LEN); LO = clog2(MAX_OUT_LEN); LI+LO SHALL be at most 12.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_data  input  16  command, weight or activation word.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  core accepts in_data; a word transfers when in_valid&&in_ready.
REQ-010 out_data  output  ACC_W  signed dot-product result.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_last  output  1  marks final column of a result vector.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 busy  output  1  state is not IDLE.

Function
REQ-015 States: IDLE, LOAD, MULT, OUT; any unreachable encoding SHALL return to IDLE next cycle.
REQ-016 in_ready SHALL be 1 in IDLE, LOAD, MULT and 0 in OUT.
REQ-017 IDLE, opcode in_data[15:12]=0xA accepted: latch in_len = in_data[11 -: LI]+1 and out_len = next LO bits +1, clear row counter, go LOAD.
REQ-018 IDLE, opcode 0xB accepted: clear all accumulators and row counter, go MULT using latched in_len/out_len.
REQ-019 IDLE, any other opcode: ignored, state unchanged.
REQ-020 LOAD: each accepted word is weight data; words per row = MAX_OUT_LEN/8; word k of row r writes columns 8k..8k+7, column 8k+j from bits [2j+1:2j].
REQ-021 Weight encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
REQ-022 Columns at or beyond out_len SHALL be stored as 0 regardless of data.
REQ-023 LOAD SHALL end after in_len*(MAX_OUT_LEN/8) accepted words, returning to IDLE the cycle after the final word; opcodes are not decoded in LOAD.
REQ-024 MULT: each accepted word supplies activation x = in_data[ACT_W-1:0] (signed, upper bits ignored) for row r; every column c < out_len SHALL update acc[c] += w[r][c]*x in that cycle; no multiplier, add/subtract/hold only.
REQ-025 After in_len activations the state SHALL be OUT on the next cycle; accumulators never overflow by ACC_W sizing.
REQ-026 OUT: out_valid=1, out_data=acc[col], col starting at 0; col advances only on out_valid&&out_ready; out_last=1 when col=out_len-1.
REQ-027 Final column transfer SHALL return to IDLE next cycle with out_valid=0; out_data and col SHALL hold while out_ready=0.
REQ-028 Weights SHALL persist across MULT operations until the next LOAD or reset; MULT before any LOAD uses all-zero weights.
REQ-029 A new 0xA SHALL overwrite only rows written; rows >= new in_len are not read.

Reset
REQ-030 rst asserted: state=IDLE, in_len=MAX_IN_LEN, out_len=MAX_OUT_LEN, all weights and accumulators 0, counters 0, out_valid=0, out_last=0, out_data=0, busy=0; in_ready=1 once rst deasserts.
REQ-031 rst mid-LOAD, MULT or OUT SHALL abort immediately with no partial output emitted afterward.

Structure
REQ-032 Package ternary_pkg holds the state enum, opcodes 0xA/0xB, weight encodings and the ACC_W/LI/LO helper functions.
REQ-033 One sub-module ternary_weight_mem: MAX_IN_LEN x MAX_OUT_LEN 2-bit store with packed row-word write port and full-row read port.

Verification
REQ-034 Load 0xA F E0 (in_len 16, out_len 8), 16 words 0x5555 (all +1), MULT 0xB with x=1..16 -> 8 results of 136, out_last on 8th.
REQ-035 Load in_len 2, out_len 3, rows 0xFFFF and 0x0001; MULT x=-128, x=5 -> results 133, 128, 128 (col2: 128), with exactly 3 out_valid beats.
REQ-036 Hold out_ready=0 for 5 cycles in OUT -> out_data, out_valid stable; in_ready=0; no column skipped.
REQ-037 Encoding 2'b10 everywhere, MULT x=100 -> all results 0.
REQ-038 Assert rst during 3rd activation of MULT -> busy=0, out_valid=0 next cycle; subsequent MULT with fresh weights is correct.
REQ-039 Opcode 0x3 in IDLE -> no state change; two consecutive MULTs without reload -> identical results.
